// File: rtl/alu_issue_pkg.sv
// Shared encodings, FSM state type and aluop decoder for the ALU issue stage.
package alu_issue_pkg;

   localparam logic [2:0] AluopAnd = 3'b000;
   localparam logic [2:0] AluopOr  = 3'b001;
   localparam logic [2:0] AluopAdd = 3'b010;
   localparam logic [2:0] AluopSub = 3'b110;

   localparam logic [1:0] OpAnd = 2'b00;
   localparam logic [1:0] OpOr  = 2'b01;
   localparam logic [1:0] OpAdd = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StWb
   } state_e;

   typedef struct packed {
      logic [1:0] operation;
      logic       binvert;
      logic       carryin;
      logic       arith;
      logic       legal;
   } ctrl_t;

   // Illegal codes fall back to AND; the caller squashes the destination.
   function automatic ctrl_t decode_aluop(input logic [2:0] aluop);
      ctrl_t c;
      c = '0;
      c.operation = OpAnd;
      c.legal = 1'b1;
      case (aluop)
         AluopAnd: c.operation = OpAnd;
         AluopOr:  c.operation = OpOr;
         AluopAdd: begin
            c.operation = OpAdd;
            c.arith = 1'b1;
         end
         AluopSub: begin
            c.operation = OpAdd;
            c.binvert = 1'b1;
            c.carryin = 1'b1;
            c.arith = 1'b1;
         end
         default: c.legal = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// regfile32x32: 32x32 register file, two async read ports, one sync write port, r0 reads zero.
module regfile32x32 (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  raddr_a,
   output logic [31:0] rdata_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_b,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] mem [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : mem[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : mem[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: reads operands, drives an external ALU, writes the result back.
// Optional ALU_ISSUE_BYPASS_EN accepts a new instruction in WB with result forwarding.
module alu_issue_stage
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [2:0]  aluop,
   input  logic        ld_en,
   input  logic [4:0]  ld_addr,
   input  logic [31:0] ld_data,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [1:0]  Operation,
   output logic        Binvert,
   output logic        Carryin,
   input  logic [31:0] alu_result,
   input  logic        alu_carry,
   output logic        wb_valid,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        carry_flag
);

   state_e      state;
   logic [4:0]  rd_q;
   logic        arith_q;
   logic        accept;
   ctrl_t       dec;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   regfile32x32 u_regfile (
      .clk     (clk),
      .reset   (reset),
      .raddr_a (rs),
      .rdata_a (rs_data),
      .raddr_b (rt),
      .rdata_b (rt_data),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata)
   );

   assign dec = decode_aluop(aluop);

   always_comb begin
`ifdef ALU_ISSUE_BYPASS_EN
      in_ready = ((state == StIdle) && !ld_en) || (state == StWb);
`else
      in_ready = (state == StIdle) && !ld_en;
`endif
      accept = in_valid && in_ready;
   end

   // The WB write lands on the same edge as acceptance, so forward it explicitly.
   always_comb begin
`ifdef ALU_ISSUE_BYPASS_EN
      op_a = ((state == StWb) && (wb_addr != 5'd0) && (rs == wb_addr)) ? wb_data : rs_data;
      op_b = ((state == StWb) && (wb_addr != 5'd0) && (rt == wb_addr)) ? wb_data : rt_data;
`else
      op_a = rs_data;
      op_b = rt_data;
`endif
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = ld_addr;
      rf_wdata = ld_data;
      if (state == StWb) begin
         rf_we    = 1'b1;
         rf_waddr = wb_addr;
         rf_wdata = wb_data;
      end else if (state == StIdle) begin
         rf_we    = ld_en;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StIdle;
         a          <= '0;
         b          <= '0;
         Operation  <= '0;
         Binvert    <= 1'b0;
         Carryin    <= 1'b0;
         rd_q       <= '0;
         arith_q    <= 1'b0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         carry_flag <= 1'b0;
      end else begin
         case (state)
            StIdle: state <= StIdle;
            StExec: begin
               wb_valid <= 1'b1;
               wb_addr  <= rd_q;
               wb_data  <= alu_result;
               if (arith_q) begin
                  carry_flag <= alu_carry;
               end
               state <= StWb;
            end
            StWb: begin
               wb_valid <= 1'b0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
         if (accept) begin
            a         <= op_a;
            b         <= op_b;
            Operation <= dec.operation;
            Binvert   <= dec.binvert;
            Carryin   <= dec.carryin;
            rd_q      <= dec.legal ? rd : 5'd0;
            arith_q   <= dec.arith;
            state     <= StExec;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a stand-in ALU and a register-level reference model.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [2:0]  aluop;
   logic        ld_en;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  Operation;
   logic        Binvert;
   logic        Carryin;
   logic [31:0] alu_result;
   logic        alu_carry;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        carry_flag;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rs         (rs),
      .rt         (rt),
      .rd         (rd),
      .aluop      (aluop),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .a          (a),
      .b          (b),
      .Operation  (Operation),
      .Binvert    (Binvert),
      .Carryin    (Carryin),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .carry_flag (carry_flag)
   );

   // Downstream ALU; logic ops return carry=1 so a spurious carry_flag update shows up.
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum = {1'b0, a} + {1'b0, (Binvert ? ~b : b)} + {32'd0, Carryin};
      alu_result = '0;
      alu_carry = 1'b0;
      case (Operation)
         2'b00: begin alu_result = a & b; alu_carry = 1'b1; end
         2'b01: begin alu_result = a | b; alu_carry = 1'b1; end
         2'b10: begin alu_result = alu_sum[31:0]; alu_carry = alu_sum[32]; end
         default: ;
      endcase
   end

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic        binv;
      logic        cin;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        cflag;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mregs[32];
   logic        mcarry;
   logic        last_in_wb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && wb_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb actual=wb_valid expected=idle t=%0t", $time);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("a", a, e.a);
            check("b", b, e.b);
            check("operation", {30'd0, Operation}, {30'd0, e.op});
            check("binvert", {31'd0, Binvert}, {31'd0, e.binv});
            check("carryin", {31'd0, Carryin}, {31'd0, e.cin});
            check("wb_addr", {27'd0, wb_addr}, {27'd0, e.wb_addr});
            check("wb_data", wb_data, e.wb_data);
            check("carry_flag", {31'd0, carry_flag}, {31'd0, e.cflag});
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      mcarry = 1'b0;
   endtask

   task automatic issue(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [2:0] op, input bit push);
      exp_t        e;
      logic [32:0] sum;
      logic        legal;
      bit          got;
      e = '0;
      legal = 1'b1;
      e.a = mregs[s];
      e.b = mregs[t];
      case (op)
         3'b000: e.wb_data = e.a & e.b;
         3'b001: begin e.wb_data = e.a | e.b; e.op = 2'b01; end
         3'b010: begin
            sum = {1'b0, e.a} + {1'b0, e.b};
            e.wb_data = sum[31:0];
            e.op = 2'b10;
            if (push) mcarry = sum[32];
         end
         3'b110: begin
            e.wb_data = e.a - e.b;
            e.op = 2'b10;
            e.binv = 1'b1;
            e.cin = 1'b1;
            if (push) mcarry = (e.a >= e.b);
         end
         default: begin e.wb_data = e.a & e.b; legal = 1'b0; end
      endcase
      e.wb_addr = legal ? d : 5'd0;
      e.cflag = mcarry;
      rs = s; rt = t; rd = d; aluop = op; in_valid = 1'b1;
      got = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) begin got = 1; break; end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=in_ready=0 expected=in_ready=1 t=%0t", $time);
         in_valid = 1'b0;
         return;
      end
      last_in_wb = wb_valid;
      if (push) begin
         sbq.push_back(e);
         if (legal && d != 5'd0) mregs[d] = e.wb_data;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("ready_in_exec", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic load(input logic [4:0] addr, input logic [31:0] data);
      bit got;
      got = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready && !wb_valid) begin got = 1; break; end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy expected=idle t=%0t", $time);
         return;
      end
      ld_en = 1'b1; ld_addr = addr; ld_data = data;
      #1 check("ready_during_load", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 ld_en = 1'b0;
      if (addr != 5'd0) mregs[addr] = data;
   endtask

   task automatic check_reset_outputs();
      check("rst_a", a, 32'd0);
      check("rst_b", b, 32'd0);
      check("rst_ctrl", {27'd0, Operation, Binvert, Carryin, carry_flag}, 32'd0);
      check("rst_wb", {wb_valid, wb_addr, 26'd0} | wb_data, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; rs = '0; rt = '0; rd = '0; aluop = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0; last_in_wb = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_outputs();

      load(5'd1, 32'h0000000B);
      load(5'd2, 32'h0000000C);
      issue(5'd1, 5'd2, 5'd3, 3'b000, 1);
      issue(5'd1, 5'd2, 5'd4, 3'b001, 1);
      issue(5'd1, 5'd2, 5'd5, 3'b010, 1);
      issue(5'd1, 5'd2, 5'd6, 3'b110, 1);
      load(5'd1, 32'h0000000C);
      load(5'd2, 32'h0000000B);
      issue(5'd1, 5'd2, 5'd6, 3'b110, 1);
      issue(5'd3, 5'd4, 5'd1, 3'b000, 1);
      issue(5'd5, 5'd6, 5'd2, 3'b001, 1);

      // r0 target, illegal opcode, and a load attempted outside IDLE
      issue(5'd1, 5'd2, 5'd0, 3'b010, 1);
      issue(5'd1, 5'd2, 5'd9, 3'b111, 1);
      ld_en = 1'b1; ld_addr = 5'd10; ld_data = 32'hDEADBEEF;
      repeat (2) @(posedge clk);
      #1 ld_en = 1'b0;
      issue(5'd10, 5'd9, 5'd0, 3'b001, 1);

      // back-to-back dependent adds
      load(5'd1, 32'h0000000B);
      load(5'd2, 32'h0000000C);
      issue(5'd1, 5'd2, 5'd8, 3'b010, 1);
      issue(5'd8, 5'd1, 5'd9, 3'b010, 1);
`ifdef ALU_ISSUE_BYPASS_EN
      check("accepted_in_wb", {31'd0, last_in_wb}, 32'd1);
`else
      check("accepted_in_wb", {31'd0, last_in_wb}, 32'd0);
`endif
      issue(5'd9, 5'd0, 5'd11, 3'b001, 1);

      // reset during EXEC discards the instruction
      issue(5'd1, 5'd2, 5'd7, 3'b010, 0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      check_reset_outputs();
      issue(5'd7, 5'd8, 5'd12, 3'b010, 1);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            load(5'($urandom_range(0, 31)),
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)));
         end else begin
            logic [2:0] op;
            case ($urandom_range(0, 4))
               0: op = 3'b000;
               1: op = 3'b001;
               2: op = 3'b010;
               3: op = 3'b110;
               default: op = 3'($urandom_range(0, 7));
            endcase
            issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), op, 1);
         end
      end

      for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d_pending expected=0_pending", sbq.size());
      end
      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have ports clk (input, 1, sole clock, rising edge) and reset (input, 1, synchronous, active-high); one clock; reset is synchronous and active-high.
REQ-002 SHALL have in_valid (input, 1): instruction offered; in_ready (output, 1): instruction accepted when both are high at a clk edge.
REQ-003 SHALL have rs, rt, rd (inputs, 5 each): source and destination register indices; aluop (input, 3): 000 AND, 001 OR, 010 ADD, 110 SUB, others illegal.
REQ-004 SHALL have ld_en (input, 1), ld_addr (input, 5), ld_data (input, 32): direct register load port.
REQ-005 SHALL have a, b (outputs, 32), Operation (output, 2), Binvert (output, 1), Carryin (output, 1): operands and controls driven to the downstream ALU.
REQ-006 SHALL have alu_result (input, 32) and alu_carry (input, 1): combinational ALU return path.
REQ-007 SHALL have wb_valid (output, 1), wb_addr (output, 5), wb_data (output, 32), carry_flag (output, 1): write-back observation and sticky carry.

Function
REQ-008 SHALL contain a 32x32 register file; r0 reads as 0 and ignores all writes.
REQ-009 SHALL implement the FSM IDLE -> EXEC -> WB -> IDLE, advancing exactly one state per cycle.
REQ-010 In IDLE, in_ready SHALL be 1 unless ld_en=1; when ld_en=1, SHALL write ld_data to ld_addr and hold in_ready=0.
REQ-011 On acceptance SHALL register reg[rs] to a, reg[rt] to b, and decoded controls, then enter EXEC; operand latency is 1 cycle.
REQ-012 Decode SHALL be: AND -> Operation=00, Binvert=0, Carryin=0; OR -> 01,0,0; ADD -> 10,0,0; SUB -> 10,1,1.
REQ-013 An illegal aluop SHALL be accepted as AND with rd forced to 0, so no register changes.
REQ-014 In EXEC, a, b and controls SHALL be stable; alu_result and alu_carry SHALL be sampled at the EXEC->WB edge.
REQ-015 In WB, SHALL write the sampled result to reg[rd], drive wb_valid=1, wb_addr=rd, wb_data=result, and update carry_flag from alu_carry only for ADD/SUB.
REQ-016 ld_en outside IDLE SHALL be ignored.
REQ-017 Outside IDLE (and outside WB when bypass is compiled in), in_ready SHALL be 0.

Reset
REQ-018 Reset SHALL clear all 32 registers, a, b, Operation, Binvert, Carryin, carry_flag, wb_valid, wb_addr and wb_data to 0, and force IDLE.
REQ-019 Reset asserted in EXEC or WB SHALL discard the instruction with no register write; in_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-020 Macro ALU_ISSUE_BYPASS_EN: when defined, in_ready SHALL also be 1 in WB, and an instruction accepted there SHALL go directly to EXEC, with any rs/rt equal to the WB rd (rd!=0) taking the WB data; when undefined, in_ready SHALL be 1 only in IDLE, giving a throughput of one instruction per 3 cycles.

Structure
REQ-021 Package alu_issue_pkg SHALL hold the aluop encodings, the Operation encodings, and the FSM state enum.
REQ-022 The register file SHALL be a sub-module, regfile32x32: 2 async read ports, 1 sync write port, reset clear, r0 hardwired to zero.

Verification
REQ-023 Load r1=0x0000000B and r2=0x0000000C, then issue AND rd=3 -> a=0xB, b=0xC, Operation=00 in EXEC; WB wb_data=0x00000008 to r3.
REQ-024 Same operands, OR rd=4 then ADD rd=5 -> r4=0x0000000F and r5=0x00000017, with carry_flag=0.
REQ-025 SUB rd=6 with r1=0xB, r2=0xC -> Binvert=1, Carryin=1; r6=0xFFFFFFFF and carry_flag=0. With r1 and r2 swapped -> r6=0x00000001 and carry_flag=1.
REQ-026 ADD rd=0 and illegal aluop=111 -> r0 stays 0, wb_addr=0, no other register changes; ld_en during EXEC -> ignored.
REQ-027 Reset in EXEC of ADD rd=7 -> r7 stays 0, FSM is in IDLE, and every output is 0 except in_ready=1.
REQ-028 With ALU_ISSUE_BYPASS_EN, back-to-back ADD r8=r1+r2 then ADD r9=r8+r1 -> second instruction is accepted in WB and r9=0x00000022. Without the macro -> second instruction waits until IDLE and gives the same value.
